seq_ctrl: RTL and testbench
===========================

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 The block SHALL run on a single clock domain; its reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op_code  in  7  opcode field of the instruction register.
REQ-005 reg_w  in  1  register-write enable from the main decoder.
REQ-006 branch  in  1  branch-taken flag, already gated with the ALU flag.
REQ-007 mem_ack  in  1  memory port acknowledge, one cycle, for the current request.
REQ-008 mem_req  out  1  request to the shared instruction/data memory port.
REQ-009 mem_we  out  1  request is a store.
REQ-010 addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
REQ-011 ir_we  out  1  instruction register load strobe.
REQ-012 pc_we  out  1  PC update strobe; retires one instruction.
REQ-013 pc_taken  out  1  PC source select: 1 = branch/jump target, 0 = PC+4.
REQ-014 rf_we  out  1  register file write strobe.
REQ-015 csr_we  out  1  CSR write strobe.
REQ-016 trap  out  1  sticky illegal-instruction indication.
REQ-017 state  out  3  current FSM state.
REQ-018 instret  out  32  retired-instruction counter.

Function
REQ-019 The FSM states and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6, CSR=7.
REQ-020 IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-021 FETCH SHALL drive mem_req=1 and addr_sel=0 until mem_ack; on mem_ack, ir_we SHALL pulse for that same cycle and the next state SHALL be DECODE.
REQ-022 DECODE SHALL last one cycle and then go to EXEC for legal opcodes and to TRAP otherwise.
REQ-023 The legal opcodes SHALL be 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, and 1110011 (the last only with CSR_SEQ_EN defined).
REQ-024 EXEC SHALL route by opcode: load/store to MEM, branch to FETCH, system to CSR, and all others to WB.
REQ-025 On a branch in EXEC, pc_we SHALL be 1 and pc_taken SHALL equal the branch input.
REQ-026 MEM SHALL drive mem_req=1 and addr_sel=1, with mem_we=1 for stores only, held stable until mem_ack.
REQ-027 On mem_ack in MEM, a store SHALL go to FETCH with pc_we=1 and pc_taken=0; a load SHALL go to WB.
REQ-028 WB SHALL last one cycle with rf_we=reg_w and pc_we=1.
REQ-029 In WB, pc_taken SHALL be 1 for opcodes 1101111 and 1100111 and 0 otherwise; the next state SHALL be FETCH.
REQ-030 TRAP SHALL be absorbing until reset, with trap=1 and all strobes and mem_req at 0.
REQ-031 mem_req, mem_we, and addr_sel SHALL be functions of state only and SHALL NOT drop before mem_ack; ir_we and pc_we SHALL be single-cycle pulses.
REQ-032 mem_ack SHALL be ignored outside FETCH and MEM.
REQ-033 instret SHALL increment by 1 on each cycle with pc_we=1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 Each instruction SHALL take: ALU 4 cycles plus fetch wait; load 5 plus waits; store and branch 3 or 4 plus waits.

Reset
REQ-035 While rst_n=0, state SHALL be IDLE, instret 0, trap 0, and all other outputs 0; this SHALL take effect immediately, including mid-request, with mem_req dropping without waiting for mem_ack.

Configuration
REQ-036 With CSR_SEQ_EN defined, opcode 1110011 SHALL be legal, and EXEC SHALL go to CSR.
REQ-037 CSR SHALL pulse csr_we for one cycle and then go to WB.
REQ-038 Without CSR_SEQ_EN, opcode 1110011 SHALL go to TRAP; the CSR state SHALL be unreachable and csr_we SHALL be tied to 0.

Structure
REQ-039 The state encodings and opcode constants SHALL live in the shared package rv32_ctrl_pkg.
REQ-040 Opcode classification (load, store, branch, jump, system, legal) SHALL be the combinational sub-module op_class.

Verification
REQ-041 Reset release followed by mem_ack on the 2nd FETCH cycle SHALL give ir_we=1 in that cycle, DECODE next, and mem_req=0 during IDLE.
REQ-042 op_code=0110011 with reg_w=1 SHALL give the sequence FETCH→DECODE→EXEC→WB, with rf_we=1 and pc_we=1 in WB and instret going 0→1.
REQ-043 op_code=0000011 with mem_ack delayed 3 cycles SHALL hold mem_req=1 and addr_sel=1 for 4 cycles, then WB with rf_we=1.
REQ-044 op_code=1100011 with branch=1 SHALL give pc_we=1 and pc_taken=1 in EXEC, then FETCH.
REQ-045 op_code=1111111 SHALL cause TRAP with trap=1 held for 10 or more cycles despite mem_ack pulses.
REQ-046 Preloading instret=0xFFFFFFFF and retiring one instruction SHALL give instret=0; asserting rst_n=0 mid-MEM SHALL drop mem_req in the same cycle.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// Shared constants for the multi-cycle sequencer: FSM state
// encodings, RV32 major opcodes and the opcode-class bundle.
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_CSR    = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic legal;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic system;
    } op_class_t;

endpackage

// File: rtl/seq_ctrl_if.sv
// Shared instruction/data memory port handshake.
// master: sequencer (mem_req/mem_we/addr_sel out, mem_ack in).
interface seq_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/op_class.sv
// Combinational opcode classifier: op_code in, op_class_t out.
// System opcode is legal only when CSR_SEQ_EN is defined.
module op_class
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] op_code,
    output op_class_t  cls
);

    always_comb begin
        cls        = '0;
        cls.load   = (op_code == OP_LOAD);
        cls.store  = (op_code == OP_STORE);
        cls.branch = (op_code == OP_BRANCH);
        cls.jump   = (op_code == OP_JAL) || (op_code == OP_JALR);
`ifdef CSR_SEQ_EN
        cls.system = (op_code == OP_SYSTEM);
        cls.legal  = op_code inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                     OP_BRANCH, OP_JAL, OP_JALR,
                                     OP_LUI, OP_AUIPC, OP_SYSTEM};
`else
        cls.system = 1'b0;
        cls.legal  = op_code inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                     OP_BRANCH, OP_JAL, OP_JALR,
                                     OP_LUI, OP_AUIPC};
`endif
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle RV32 control sequencer with retired-instruction counter.
// Ports: clk, rst_n, mem (seq_ctrl_if.master), op_code, reg_w, branch,
//   instret_wr/instret_wdata (counter preload), ir_we, pc_we, pc_taken,
//   rf_we, csr_we, trap, state, instret. Option macro: CSR_SEQ_EN.
module seq_ctrl
    import rv32_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    seq_ctrl_if.master  mem,
    input  logic [6:0]  op_code,
    input  logic        reg_w,
    input  logic        branch,
    input  logic        instret_wr,
    input  logic [31:0] instret_wdata,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_taken,
    output logic        rf_we,
    output logic        csr_we,
    output logic        trap,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    state_t      state_q;
    state_t      state_d;
    op_class_t   cls;
    logic [31:0] instret_q;
    logic        req_c;
    logic        we_c;
    logic        asel_c;

    op_class u_op_class (
        .op_code (op_code),
        .cls     (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            // Preload wins over a same-cycle retire.
            if (instret_wr)
                instret_q <= instret_wdata;
            else if (pc_we)
                instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        asel_c   = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_taken = 1'b0;
        rf_we    = 1'b0;
        csr_we   = 1'b0;
        trap     = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = cls.legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                unique case (1'b1)
                    cls.load, cls.store: state_d = S_MEM;
                    cls.branch: begin
                        pc_we    = 1'b1;
                        pc_taken = branch;
                        state_d  = S_FETCH;
                    end
`ifdef CSR_SEQ_EN
                    cls.system: state_d = S_CSR;
`endif
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // Request qualifiers hold until the ack arrives.
                req_c  = 1'b1;
                asel_c = 1'b1;
                we_c   = cls.store;
                if (mem.mem_ack) begin
                    if (cls.store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = reg_w;
                pc_we    = 1'b1;
                pc_taken = cls.jump;
                state_d  = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            S_CSR: begin
`ifdef CSR_SEQ_EN
                csr_we  = 1'b1;
                state_d = S_WB;
`else
                state_d = S_TRAP;
`endif
            end
        endcase
    end

    assign mem.mem_req  = req_c;
    assign mem.mem_we   = we_c;
    assign mem.addr_sel = asel_c;
    assign state        = state_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Randomized self-checking bench for seq_ctrl against a
// phase-schedule reference model of the instruction timeline.
module tb_seq_ctrl;

    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] DEC   = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] MEM   = 3'd4;
    localparam logic [2:0] WB    = 3'd5;
    localparam logic [2:0] TRAP  = 3'd6;
`ifdef CSR_SEQ_EN
    localparam logic [2:0] CSR   = 3'd7;
`endif

    typedef struct {
        logic [2:0] st;
        logic       req, we, asel, ir, pc, tk, rf, csr, trp;
        logic       ack, ld;
        logic [6:0] op;
        logic       rw, br;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op_code = '0;
    logic        reg_w = 1'b0;
    logic        branch = 1'b0;
    logic        instret_wr = 1'b0;
    logic [31:0] instret_wdata = '0;
    logic        ir_we, pc_we, pc_taken, rf_we, csr_we, trap;
    logic [2:0]  state;
    logic [31:0] instret;

    seq_ctrl_if mif ();

    seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem           (mif),
        .op_code       (op_code),
        .reg_w         (reg_w),
        .branch        (branch),
        .instret_wr    (instret_wr),
        .instret_wdata (instret_wdata),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_taken      (pc_taken),
        .rf_we         (rf_we),
        .csr_we        (csr_we),
        .trap          (trap),
        .state         (state),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] model_cnt = '0;
    cyc_t        q[$];
    logic [6:0]  legal_ops[$];
    logic [6:0]  cur_op;
    logic        cur_rw, cur_br;

    task automatic check_eq(string tag, logic [31:0] got,
                            logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] got_vec();
        return {20'd0, state, mif.mem_req, mif.mem_we, mif.addr_sel,
                ir_we, pc_we, pc_taken, rf_we, csr_we, trap};
    endfunction

    function automatic logic [31:0] exp_vec(cyc_t e);
        return {20'd0, e.st, e.req, e.we, e.asel,
                e.ir, e.pc, e.tk, e.rf, e.csr, e.trp};
    endfunction

    task automatic push(logic [2:0] st, logic req, logic we,
                        logic asel, logic ir, logic pc, logic tk,
                        logic rf, logic csr, logic trp, logic ack,
                        logic ld);
        cyc_t e;
        e.st = st; e.req = req; e.we = we; e.asel = asel;
        e.ir = ir; e.pc = pc; e.tk = tk; e.rf = rf;
        e.csr = csr; e.trp = trp; e.ack = ack; e.ld = ld;
        e.op = cur_op; e.rw = cur_rw; e.br = cur_br;
        q.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Timeline of one instruction from the opcode's class:
    // fetch waits, decode, then the class-specific phases.
    task automatic build(logic [6:0] op, logic rw, logic br,
                         int wf, int wm, logic ld);
        logic is_ld, is_st, is_br, is_jmp, is_sys, legal;
        cur_op = op; cur_rw = rw; cur_br = br;
        is_ld  = (op == 7'b0000011);
        is_st  = (op == 7'b0100011);
        is_br  = (op == 7'b1100011);
        is_jmp = (op == 7'b1101111) || (op == 7'b1100111);
        is_sys = (op == 7'b1110011);
        legal  = 1'b0;
        foreach (legal_ops[i])
            if (legal_ops[i] == op) legal = 1'b1;
        for (int i = 0; i <= wf; i++)
            push(FETCH, 1, 0, 0, i == wf, 0, 0, 0, 0, 0, i == wf, 0);
        push(DEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, rbit(), ld);
        if (!legal) begin
            for (int i = 0; i < 12; i++)
                push(TRAP, 0, 0, 0, 0, 0, 0, 0, 0, 1, rbit(), 0);
            return;
        end
        if (is_br) begin
            push(EXEC, 0, 0, 0, 0, 1, br, 0, 0, 0, rbit(), 0);
            return;
        end
        push(EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, rbit(), 0);
        if (is_ld || is_st) begin
            for (int i = 0; i <= wm; i++)
                push(MEM, 1, is_st, 1, 0, is_st && i == wm, 0,
                     0, 0, 0, i == wm, 0);
            if (is_st) return;
        end
`ifdef CSR_SEQ_EN
        if (is_sys)
            push(CSR, 0, 0, 0, 0, 0, 0, 0, 1, 0, rbit(), 0);
`else
        if (is_sys) return;
`endif
        push(WB, 0, 0, 0, 0, 1, is_jmp, rw, 0, 0, rbit(), 0);
    endtask

    task automatic run(int n);
        cyc_t e;
        int   k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            e = q.pop_front();
            @(negedge clk);
            op_code       = e.op;
            reg_w         = e.rw;
            branch        = e.br;
            mif.mem_ack   = e.ack;
            instret_wr    = e.ld;
            instret_wdata = 32'hFFFF_FFFF;
            #1;
            check_eq($sformatf("out@%0d", cyc), got_vec(), exp_vec(e));
            check_eq($sformatf("instret@%0d", cyc), instret, model_cnt);
            if (e.ld)
                model_cnt = 32'hFFFF_FFFF;
            else if (e.pc)
                model_cnt = model_cnt + 32'd1;
            k++;
            cyc++;
        end
    endtask

    task automatic do_reset(logic ack);
        @(negedge clk);
        rst_n       = 1'b0;
        mif.mem_ack = ack;
        instret_wr  = 1'b0;
        #1;
        check_eq("rst_out", got_vec(), 32'd0);
        check_eq("rst_cnt", instret, 32'd0);
        repeat (2) @(negedge clk);
        mif.mem_ack = 1'b1;
        #1;
        check_eq("rst_hold", got_vec(), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        mif.mem_ack = rbit();
        #1;
        check_eq("idle_out", got_vec(), 32'd0);
        model_cnt = '0;
        q.delete();
    endtask

    initial begin
        mif.mem_ack = 1'b0;
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                      7'b0010111};
`ifdef CSR_SEQ_EN
        legal_ops.push_back(7'b1110011);
`endif
        do_reset(1'b1);
        // ALU op, ack on 2nd fetch cycle
        build(7'b0110011, 1, rbit(), 1, 0, 0);
        run(-1);
        // Load with 3-cycle memory wait
        build(7'b0000011, 1, 0, 0, 3, 0);
        run(-1);
        // Taken branch
        build(7'b1100011, rbit(), 1, 0, 0, 0);
        run(-1);
        // Counter preload then retire: wraps to 0
        build(7'b0110011, 1, 0, 0, 0, 1);
        run(-1);
        build(7'b1101111, 1, 0, 0, 0, 0);
        run(-1);
        for (int n = 0; n < 60; n++) begin
            build(legal_ops[$urandom_range(0, legal_ops.size() - 1)],
                  rbit(), rbit(), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 0);
            run(-1);
        end
        // Reset in the middle of a pending load request
        build(7'b0000011, 1, 0, 0, 6, 0);
        run(5);
        do_reset(1'b0);
        // Illegal opcode: trap is absorbing
        build(7'b1111111, 1, 1, 0, 0, 0);
        run(-1);
        do_reset(1'b1);
        build(7'b1110011, 1, 0, 1, 0, 0);
        run(-1);
        do_reset(1'b1);
        build(7'b0100011, 0, 0, 2, 2, 0);
        run(-1);
        build(7'b0010111, 1, 0, 0, 0, 0);
        run(-1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
